// File: rtl/memsync_pkg.sv
// memsync_pkg: shared FSM states, request op and tag-entry layout for memsync_assoc
package memsync_pkg;
  localparam int TAG_MAX = 32;
  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_WB, S_ALLOC, S_HIT, S_FLUSH, S_FLUSH_WB
  } state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
  typedef struct packed {
    logic [TAG_MAX-1:0] tag;
    logic               valid;
    logic               dirty;
  } entry_t;
endpackage

// File: rtl/memsync_assoc_if.sv
// memsync_assoc_if: request front-end and row-transfer handshake bundle for memsync_assoc
interface memsync_assoc_if #(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17
);
  logic                 RD;
  logic                 WR;
  logic [ADDRWIDTH-1:0] RowId;
  logic                 sync;
  logic                 flush;
  logic                 stall;
  logic [CHWIDTH-1:0]   cRowId;
  logic [ADDRWIDTH-1:0] wbRowId;
  logic                 wb;
  logic                 alloc;
  logic                 flush_done;
  modport master (
    output RD, WR, RowId, sync, flush,
    input  stall, cRowId, wbRowId, wb, alloc, flush_done
  );
  modport slave (
    input  RD, WR, RowId, sync, flush,
    output stall, cRowId, wbRowId, wb, alloc, flush_done
  );
endinterface

// File: rtl/memsync_tagram.sv
// memsync_tagram: tag/valid/dirty store with per-set round-robin pointers; lookup, install, mark/clear dirty, invalidate
module memsync_tagram import memsync_pkg::*; #(
  parameter int CHWIDTH   = 6,
  parameter int WAYWIDTH  = 1,
  parameter int ADDRWIDTH = 17,
  localparam int SETW     = CHWIDTH - WAYWIDTH,
  localparam int TAGW     = ADDRWIDTH - SETW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SETW-1:0]      set,
  input  logic [TAGW-1:0]      tag,
  output logic                 hit,
  output logic [CHWIDTH-1:0]   hit_idx,
  output logic [CHWIDTH-1:0]   vic_idx,
  input  logic [CHWIDTH-1:0]   idx,
  output logic                 ent_dirty,
  output logic [ADDRWIDTH-1:0] ent_row,
  input  logic                 ins,
  input  logic                 ins_dirty,
  input  logic                 set_dirty,
  input  logic                 clr_dirty,
  input  logic                 inv
);
  localparam int NENT = 2**CHWIDTH;
  localparam int NSET = 2**SETW;
  localparam int WAYS = 2**WAYWIDTH;
  localparam int WW   = (WAYWIDTH == 0) ? 1 : WAYWIDTH;
  entry_t           ent_q [NENT];
  logic [WW-1:0]    rr_q  [NSET];
  logic [CHWIDTH-1:0] base;
  logic [SETW-1:0]  iset;
  assign base      = CHWIDTH'(set) << WAYWIDTH;
  assign iset      = SETW'(idx >> WAYWIDTH);
  assign ent_dirty = ent_q[idx].valid & ent_q[idx].dirty;
  assign ent_row   = {ent_q[idx].tag[TAGW-1:0], iset};
  // scan ways high-to-low so the lowest matching/invalid way wins; pointer is the fallback victim
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    vic_idx = base | CHWIDTH'(rr_q[set]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ent_q[base | CHWIDTH'(w)].valid && ent_q[base | CHWIDTH'(w)].tag == TAG_MAX'(tag)) begin
        hit     = 1'b1;
        hit_idx = base | CHWIDTH'(w);
      end
      if (!ent_q[base | CHWIDTH'(w)].valid) vic_idx = base | CHWIDTH'(w);
    end
  end
  // entry updates; install also steps the owning set's round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NENT; i++) ent_q[i] <= '0;
      for (int i = 0; i < NSET; i++) rr_q[i] <= '0;
    end else begin
      if (ins) begin
        ent_q[idx]  <= '{tag: TAG_MAX'(tag), valid: 1'b1, dirty: ins_dirty};
        rr_q[iset]  <= (rr_q[iset] == WW'(WAYS - 1)) ? '0 : rr_q[iset] + 1'b1;
      end
      if (set_dirty) ent_q[idx].dirty <= 1'b1;
      if (clr_dirty) ent_q[idx].dirty <= 1'b0;
      if (inv) begin
        ent_q[idx].valid <= 1'b0;
        ent_q[idx].dirty <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/memsync_assoc.sv
// memsync_assoc: set-associative row-sync controller; MEMSYNC_FLUSH_EN builds the dirty-entry flush walk
module memsync_assoc import memsync_pkg::*; #(
  parameter int CHWIDTH   = 6,
  parameter int WAYWIDTH  = 1,
  parameter int ADDRWIDTH = 17
) (
  input logic            clk,
  input logic            rst,
  memsync_assoc_if.slave bus
);
  localparam int SETW = CHWIDTH - WAYWIDTH;
  state_e               state;
  op_e                  op;
  logic [ADDRWIDTH-1:0] row;
  logic [CHWIDTH-1:0]   idx_r;
  logic [CHWIDTH-1:0]   crow;
  logic [ADDRWIDTH-1:0] wb_row;
  logic                 fdone;
  logic                 hit;
  logic [CHWIDTH-1:0]   hit_idx;
  logic [CHWIDTH-1:0]   vic_idx;
  logic [CHWIDTH-1:0]   cmp_idx;
  logic [CHWIDTH-1:0]   acc_idx;
  logic                 ent_dirty;
  logic [ADDRWIDTH-1:0] ent_row;
  assign cmp_idx = hit ? hit_idx : vic_idx;
  assign acc_idx = (state == S_CMP) ? cmp_idx : idx_r;
  memsync_tagram #(
    .CHWIDTH  (CHWIDTH),
    .WAYWIDTH (WAYWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_tagram (
    .clk      (clk),
    .rst      (rst),
    .set      (row[SETW-1:0]),
    .tag      (row[ADDRWIDTH-1:SETW]),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .vic_idx  (vic_idx),
    .idx      (acc_idx),
    .ent_dirty(ent_dirty),
    .ent_row  (ent_row),
    .ins      (state == S_ALLOC && bus.sync),
    .ins_dirty(op == OP_WR),
    .set_dirty(state == S_CMP && hit && op == OP_WR),
    .clr_dirty(state == S_FLUSH_WB && bus.sync),
    .inv      (state == S_WB && bus.sync)
  );
  assign bus.stall      = (state inside {S_CMP, S_WB, S_ALLOC, S_FLUSH, S_FLUSH_WB}) ||
                          (state == S_IDLE && (bus.RD || bus.WR));
  assign bus.cRowId     = crow;
  assign bus.wbRowId    = wb_row;
  assign bus.wb         = state == S_WB || state == S_FLUSH_WB;
  assign bus.alloc      = state == S_ALLOC;
  assign bus.flush_done = fdone;
  // request FSM; CMP acts on the latched row so RowId may wander while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op     <= OP_RD;
      row    <= '0;
      idx_r  <= '0;
      crow   <= '0;
      wb_row <= '0;
      fdone  <= 1'b0;
    end else begin
      fdone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.RD || bus.WR) begin
            row   <= bus.RowId;
            op    <= bus.WR ? OP_WR : OP_RD;
            state <= S_CMP;
          end
`ifdef MEMSYNC_FLUSH_EN
          else if (bus.flush) begin
            idx_r <= '0;
            state <= S_FLUSH;
          end
`endif
        end
        S_CMP: begin
          if (hit) begin
            crow  <= cmp_idx;
            state <= S_HIT;
          end else begin
            idx_r  <= cmp_idx;
            wb_row <= ent_dirty ? ent_row : wb_row;
            state  <= ent_dirty ? S_WB : S_ALLOC;
          end
        end
        S_WB: state <= bus.sync ? S_ALLOC : S_WB;
        S_ALLOC: begin
          if (bus.sync) begin
            crow  <= idx_r;
            state <= S_HIT;
          end
        end
        S_HIT: state <= (bus.RD || bus.WR) ? S_HIT : S_IDLE;
`ifdef MEMSYNC_FLUSH_EN
        S_FLUSH: begin
          if (ent_dirty) begin
            wb_row <= ent_row;
            state  <= S_FLUSH_WB;
          end else if (&idx_r) begin
            fdone <= 1'b1;
            state <= S_IDLE;
          end else idx_r <= idx_r + 1'b1;
        end
        S_FLUSH_WB: begin
          if (bus.sync) begin
            if (&idx_r) begin
              fdone <= 1'b1;
              state <= S_IDLE;
            end else begin
              idx_r <= idx_r + 1'b1;
              state <= S_FLUSH;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/memsync_assoc.md
# memsync_assoc

Set-associative successor to the direct row-sync controller. It tracks which DRAM rows are resident in the channel row cache using a tag table of 2**CHWIDTH entries organised as 2**WAYWIDTH ways. Per-entry valid and dirty bits are kept, replacement is invalid-first then round-robin, and write-back and allocate steps are paced by the external `sync` handshake. It sits between the request front-end (RD/WR/RowId) and the row-transfer engine that pulses `sync`.

## Interface
- CHWIDTH, 6: log2 of total cache entries.
- WAYWIDTH, 1: log2 of ways; 0 ≤ WAYWIDTH ≤ CHWIDTH.
- ADDRWIDTH, 17: row address width; must exceed SETW = CHWIDTH−WAYWIDTH.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RD  in  1  read request level.
- WR  in  1  write request level; wins over RD if both are high.
- RowId  in  ADDRWIDTH  requested row; held stable while RD|WR is high.
- sync  in  1  transfer-complete pulse; sampled only in WB, ALLOC and FLUSH.
- flush  in  1  request write-back of all dirty entries (see Configuration).
- stall  out  1  requester must wait.
- cRowId  out  CHWIDTH  cache entry index {set, way} of the resolved request.
- wbRowId  out  ADDRWIDTH  full row address of the entry being written back.
- wb  out  1  high in WB and FLUSH_WB.
- alloc  out  1  high in ALLOC.
- flush_done  out  1  one-cycle pulse when a flush completes.

## Operation
- Address split: set = RowId[SETW−1:0]; tag = RowId[ADDRWIDTH−1:SETW]. wbRowId = {victim tag, set}.
- States: IDLE, CMP, WB, ALLOC, HIT, FLUSH_WB.
- IDLE
  - If RD|WR: latch RowId and the op (write if WR), then go to CMP.
  - Else if flush: go to the flush walk.
  - sync is ignored.
- CMP (exactly 1 cycle): compare all ways of the set.
  - Hit: cRowId ← hit index; set dirty if write; go to HIT.
  - Miss, victim invalid or clean: go to ALLOC.
  - Miss, victim valid and dirty: wbRowId ← victim row; go to WB.
- Victim selection: lowest-index invalid way. If none, the set's round-robin pointer.
- WB: on sync, clear victim valid and dirty, go to ALLOC.
- ALLOC: on sync:
  - write tag, valid=1, dirty=op;
  - cRowId ← {set, victim};
  - advance the set's pointer (mod ways);
  - go to HIT.
- HIT: hold until RD=WR=0 is sampled, then go to IDLE. A new request needs at least one idle cycle in between.
- stall (combinational) = state∈{CMP, WB, ALLOC, FLUSH_WB} or (IDLE and (RD|WR)).
- Outputs at reset: stall=0 (with RD=WR=0), cRowId=0, wbRowId=0, wb=0, alloc=0, flush_done=0.
- Reset clears all valid bits, dirty bits, pointers and state, including mid-WB/ALLOC. Any partial install is discarded.

## Timing
- Request first sampled at edge k moves the FSM to CMP.
- Hit: HIT after edge k+1; stall low from k+1. Latency is 2 edges.
- Clean miss: ALLOC after k+1, HIT at the edge sampling sync.
- Dirty miss: WB after k+1; first sync → ALLOC; second sync → HIT.
- sync is a one-cycle pulse. A 2-cycle pulse in WB advances through both WB and ALLOC. This is legal and intentional.
- RowId changes while stall=1 are ignored, because the latched copy is used.

## Configuration
- MEMSYNC_FLUSH_EN defined:
  - flush in IDLE walks entries 0…2**CHWIDTH−1 in ascending order.
  - Each valid dirty entry enters FLUSH_WB with wbRowId set. On sync its dirty bit is cleared.
  - After the last entry, flush_done pulses for 1 cycle and the FSM returns to IDLE.
  - stall stays high throughout.
  - RD|WR in IDLE takes priority over flush.
- MEMSYNC_FLUSH_EN undefined: the flush port exists but is ignored, flush_done is tied 0, and FLUSH_WB is not built.

## Structure
- memsync_pkg holds:
  - the state enum;
  - the tag-entry struct (tag, valid, dirty);
  - the op enum (RD/WR).
- Sub-module memsync_tagram holds the tag/valid/dirty storage and per-set round-robin pointers. Its operations are lookup, install, clear-dirty and invalidate.
- The FSM lives in memsync_assoc.

## Test plan
Configuration: CHWIDTH=3, WAYWIDTH=1, ADDRWIDTH=8 (4 sets, 2 ways).
- After reset, WR RowId=0x14 (set 0): ALLOC with stall=1, alloc=1; one sync gives HIT, cRowId=0, stall=0.
- Repeat WR 0x14: hit after 2 edges, cRowId=0, alloc never asserted.
- RD 0x24 installs cRowId=1. WR 0x34 then gives WB with wbRowId=0x14; sync → ALLOC; sync → HIT with cRowId=0. RD 0x44 evicts clean 0x24 with no WB.
- rst low during WB: FSM in IDLE, stall=0, all entries invalid; RD 0x14 then misses with no WB.
- RD=WR=1 on 0x18 followed later by eviction of that entry: a WB occurs, proving dirty was set. A sync pulse in IDLE or HIT causes no state change.
- MEMSYNC_FLUSH_EN, two dirty entries (index 0 and 5): two WB handshakes in ascending index order, then flush_done for 1 cycle; a second flush produces no WB. Without the macro, flush has no effect.
